// File: rtl/prbs_lfsr_checker_pkg.sv
// Shared PRBS-32 definitions: checker state encoding and default generator polynomial.
package prbs_lfsr_checker_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int          PRBS_WIDTH = 32;
    // x^32 + x^22 + x^2 + x + 1, applied to a history whose bit 0 is the newest bit
    localparam logic [31:0] PRBS_TAPS  = 32'h80200003;

endpackage

// File: rtl/prbs_lfsr_checker_predict.sv
// Next-bit predictor for the PRBS recurrence; shared by generator and checker.
module prbs_lfsr_predict
    import prbs_lfsr_checker_pkg::*;
#(
    parameter int               WIDTH = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRBS_TAPS)
) (
    input  logic [WIDTH-1:0] hist,
    output logic             pred
);

    assign pred = ^(hist & TAPS);

endmodule

// File: rtl/prbs_lfsr_checker.sv
// PRBS-32 receive checker: self-synchronising search, flywheel lock, BER counters.
// Build option PRBS_CHK_SATURATE_EN: counters stick at all-ones instead of wrapping.
module prbs_lfsr_checker
    import prbs_lfsr_checker_pkg::*;
#(
    parameter int               WIDTH     = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(PRBS_TAPS),
    parameter int               LOCK_CNT  = 64,
    parameter int               WIN_LEN   = 256,
    parameter int               LOSS_ERRS = 16,
    parameter int               CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WINC_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] LOCK_HIT  = MATCH_W'(LOCK_CNT);
    localparam logic [WINC_W-1:0]  WIN_LAST  = WINC_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  LOSS_HIT  = WERR_W'(LOSS_ERRS);

    chk_state_t         state;
    chk_state_t         state_nxt;
    logic [WIDTH-1:0]   hist;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WINC_W-1:0]  win_cnt;
    logic [WERR_W-1:0]  win_err;

    logic               pred;
    logic               fill_done;
    logic               mismatch;
    logic               hit;
    logic [MATCH_W-1:0] match_nxt;
    logic [WERR_W-1:0]  werr_nxt;

    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
`ifdef PRBS_CHK_SATURATE_EN
        if (inc && (base != '1)) base = base + CNT_W'(1);
`else
        if (inc) base = base + CNT_W'(1);
`endif
        return base;
    endfunction

    prbs_lfsr_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .hist  (hist),
        .pred  (pred)
    );

    always_comb begin
        state_nxt = state;
        fill_done = (fill_cnt == FILL_FULL);
        mismatch  = (din != pred);
        // an all-zero history predicts zero forever, so it must never build lock
        hit       = !mismatch && (hist != '0);
        match_nxt = hit ? (match_cnt + MATCH_W'(1)) : '0;
        // counter back at zero marks the first bit of a fresh window
        werr_nxt  = ((win_cnt == '0) ? '0 : win_err) + WERR_W'(mismatch);
        if (din_valid) begin
            case (state)
                SEARCH:  if (fill_done && (match_nxt == LOCK_HIT)) state_nxt = LOCKED;
                LOCKED:  if (werr_nxt == LOSS_HIT) state_nxt = SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nxt;
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            err_count <= cnt_step(err_count, din_valid && (state == LOCKED) && mismatch, clear);
            bit_count <= cnt_step(bit_count, din_valid && (state == LOCKED), clear);
            if (din_valid) begin
                if (state == SEARCH) begin
                    hist    <= {hist[WIDTH-2:0], din};
                    win_cnt <= '0;
                    win_err <= '0;
                    if (!fill_done) fill_cnt  <= fill_cnt + FILL_W'(1);
                    else            match_cnt <= match_nxt;
                end else begin
                    // flywheel: feed our own prediction so a bad bit cannot corrupt history
                    hist      <= {hist[WIDTH-2:0], pred};
                    err_pulse <= mismatch;
                    win_cnt   <= (win_cnt == WIN_LAST) ? '0 : (win_cnt + WINC_W'(1));
                    win_err   <= werr_nxt;
                    if (state_nxt == SEARCH) begin
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// Self-checking bench for prbs_lfsr_checker: directed scenarios plus randomized streams vs a queue model.
`timescale 1ns/1ps
module tb_prbs_lfsr_checker;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          clear = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;

    prbs_lfsr_checker #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit gq[$];
    bit mq[$];
    bit m_locked, m_pulse;
    int m_ec, m_bc, m_fill, m_match, m_k, m_win, m_werr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_inc(input int x);
`ifdef PRBS_CHK_SATURATE_EN
        return (x == (1 << CW) - 1) ? x : x + 1;
`else
        return (x + 1) % (1 << CW);
`endif
    endfunction

    task automatic gen_seed(input logic [31:0] s);
        gq.delete();
        for (int i = 0; i < 32; i++) gq.push_back(s[i]);
    endtask

    // b[n] = b[n-1] ^ b[n-2] ^ b[n-22] ^ b[n-32]; gq[0] is the newest bit
    task automatic gen_next(output bit b);
        b = gq[0] ^ gq[1] ^ gq[21] ^ gq[31];
        gq.push_front(b);
        void'(gq.pop_back());
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mq.push_back(1'b0);
        m_locked = 0; m_pulse = 0;
        m_ec = 0; m_bc = 0; m_fill = 0; m_match = 0; m_k = 0; m_win = 0; m_werr = 0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit c);
        bit p, nz;
        m_pulse = 0;
        if (c) begin m_ec = 0; m_bc = 0; end
        if (v) begin
            p  = mq[0] ^ mq[1] ^ mq[21] ^ mq[31];
            nz = 0;
            foreach (mq[i]) if (mq[i]) nz = 1;
            if (!m_locked) begin
                if (m_fill < 32) m_fill++;
                else if (d == p && nz) begin
                    m_match++;
                    if (m_match == 64) begin
                        m_locked = 1; m_k = 0; m_win = 0; m_werr = 0;
                    end
                end else m_match = 0;
                mq.push_front(d);
            end else begin
                m_bc = cnt_inc(m_bc);
                if (m_k / 256 != m_win) begin m_win = m_k / 256; m_werr = 0; end
                if (d != p) begin
                    m_pulse = 1;
                    m_ec = cnt_inc(m_ec);
                    m_werr++;
                    if (m_werr == 16) begin m_locked = 0; m_fill = 0; m_match = 0; end
                end
                m_k++;
                mq.push_front(p);
            end
            void'(mq.pop_back());
        end
    endtask

    task automatic step(input bit d, input bit v, input bit c);
        din = d; din_valid = v; clear = c;
        @(posedge clk); #1;
        model_step(d, v, c);
        check_eq("locked",    32'(locked),    32'(m_locked));
        check_eq("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check_eq("err_count", 32'(err_count), 32'(m_ec));
        check_eq("bit_count", 32'(bit_count), 32'(m_bc));
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_locked"}, 32'(locked),    0);
        check_eq({pfx, "_pulse"},  32'(err_pulse), 0);
        check_eq({pfx, "_errs"},   32'(err_count), 0);
        check_eq({pfx, "_bits"},   32'(bit_count), 0);
    endtask

    task automatic do_reset();
        rst_n = 0; din_valid = 0; clear = 0; din = 0;
        #1;
        model_reset();
        check_zero("rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bit b, e, v, c, ever;
        int pulses, inj, drop_i;
        bit err_pos[0:400];
        int exp6;

        // 1: clean stream from the reference seed
        do_reset();
        gen_seed(32'h00003039);
        pulses = 0;
        for (int i = 1; i <= 200; i++) begin
            gen_next(b);
            step(b, 1, 0);
            pulses += int'(err_pulse);
            if (i == 95) check_eq("t1_prelock", 32'(locked), 0);
            if (i == 96) check_eq("t1_lock", 32'(locked), 1);
        end
        check_eq("t1_bits", 32'(bit_count), 104);
        check_eq("t1_errs", 32'(err_count), 0);
        check_eq("t1_pulses", pulses, 0);

        // 2: single inverted bit while locked
        do_reset();
        gen_seed(32'h00003039);
        pulses = 0;
        for (int i = 1; i <= 200; i++) begin
            gen_next(b);
            step(b ^ (i == 150), 1, 0);
            pulses += int'(err_pulse);
        end
        check_eq("t2_errs", 32'(err_count), 1);
        check_eq("t2_locked", 32'(locked), 1);
        check_eq("t2_pulses", pulses, 1);

        // 3: 16 errors in one window force loss, then relock on clean bits
        do_reset();
        gen_seed(32'h00003039);
        foreach (err_pos[i]) err_pos[i] = 0;
        inj = 0;
        while (inj < 16) begin
            int r;
            r = $urandom_range(200, 120);
            if (!err_pos[r]) begin err_pos[r] = 1; inj++; end
        end
        inj = 0; drop_i = -1000;
        for (int i = 1; i <= 300; i++) begin
            gen_next(b);
            step(b ^ err_pos[i], 1, 0);
            if (err_pos[i]) begin
                inj++;
                if (inj == 15) check_eq("t3_hold", 32'(locked), 1);
                if (inj == 16) begin check_eq("t3_drop", 32'(locked), 0); drop_i = i; end
            end
            if (i == drop_i + 95) check_eq("t3_prerelock", 32'(locked), 0);
            if (i == drop_i + 96) check_eq("t3_relock", 32'(locked), 1);
        end
        check_eq("t3_errs", 32'(err_count), 16);

        // 4: all-zero input must never lock
        do_reset();
        ever = 0;
        for (int i = 0; i < 500; i++) begin
            step(1'b0, 1, 0);
            ever |= locked;
        end
        check_eq("t4_never", 32'(ever), 0);

        // 5: gapped valid gives identical counts; async reset clears outputs immediately
        do_reset();
        gen_seed(32'h00003039);
        for (int i = 1; i <= 200; i++) begin
            step(1'($urandom_range(1, 0)), 0, 0);
            gen_next(b);
            step(b, 1, 0);
        end
        check_eq("t5_bits", 32'(bit_count), 104);
        check_eq("t5_errs", 32'(err_count), 0);
        gen_next(b);
        step(~b, 1, 0);
        check_eq("t5_pre_errs", 32'(err_count), 1);
        #2;
        rst_n = 0;
        #1;
        check_zero("t5_async");
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // 6: counter overflow behaviour, then clear coinciding with an error
        do_reset();
        gen_seed($urandom | 32'h1);
        for (int i = 0; i < 96; i++) begin gen_next(b); step(b, 1, 0); end
        check_eq("t6_lock", 32'(locked), 1);
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < 31; j++) begin gen_next(b); step(b, 1, 0); end
            gen_next(b);
            step(~b, 1, 0);
        end
`ifdef PRBS_CHK_SATURATE_EN
        exp6 = 255;
`else
        exp6 = 300 % 256;
`endif
        check_eq("t6_errs", 32'(err_count), exp6);
        check_eq("t6_locked", 32'(locked), 1);
        gen_next(b);
        step(~b, 1, 1);
        check_eq("t6_clr_err", 32'(err_count), 1);
        check_eq("t6_clr_bits", 32'(bit_count), 1);

        // randomized: reseeds mid-lock, valid gaps, sparse errors, occasional clear
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            gen_seed($urandom | 32'h1);
            for (int i = 0; i < 800; i++) begin
                v = ($urandom_range(3, 0) != 0);
                e = ($urandom_range(63, 0) == 0);
                c = ($urandom_range(199, 0) == 0);
                if (v) begin
                    gen_next(b);
                    step(b ^ e, 1, c);
                end else begin
                    step(1'($urandom_range(1, 0)), 0, c);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
